// File: rtl/io_pkg.sv
// io_pkg: default parameter values and control-register offsets shared by io_intr_port,
// its interface bundle and its bench.
package io_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 10;
  localparam int DEPTH_DEF  = 256;
  localparam int N_CH_DEF   = 4;

  // Offsets within the control page (Addr[ADDR_W-1] = 1), decoded from Addr[1:0].
  typedef enum logic [1:0] {
    REG_PEND = 2'd0,
    REG_MASK = 2'd1,
    REG_FSEL = 2'd2,
    REG_ID   = 2'd3
  } ctl_reg_e;

endpackage

// File: rtl/io_intr_port_if.sv
// io_intr_port_if: host-bus strobes plus interrupt lines of io_intr_port. The shared Data bus
// stays a resolved net at the instantiating level because several parties drive it.
interface io_intr_port_if
  import io_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int N_CH   = N_CH_DEF
);

  // Bus access: strobes are active-low levels qualified by Enable; a write commits on the
  // rising Clk while Enable & !CS_ & !WR_, and a read drives Data combinationally while
  // Enable & !CS_ & !RD_ & WR_ (Data is never driven during a write).
  logic [ADDR_W-1:0]       Addr;
  logic                    CS_;
  logic                    RD_;
  logic                    WR_;
  logic                    Enable;
  logic [N_CH-1:0]         ev_in;
  logic                    int_ack;
  logic                    fintr_req;
  logic                    intr_req;
  logic [$clog2(N_CH)-1:0] int_id;

  modport master (
    output Addr, CS_, RD_, WR_, Enable, ev_in, int_ack,
    input  fintr_req, intr_req, int_id
  );

  modport slave (
    input  Addr, CS_, RD_, WR_, Enable, ev_in, int_ack,
    output fintr_req, intr_req, int_id
  );

endinterface

// File: rtl/io_prio_enc.sv
// io_prio_enc: lowest-index-wins priority encoder; idx is 0 when no request is present.
module io_prio_enc #(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]         req,
  output logic                    valid,
  output logic [$clog2(N_CH)-1:0] idx
);

  localparam int IDX_W = $clog2(N_CH);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/io_intr_port.sv
// io_intr_port: buffer memory plus PEND/MASK/FSEL/ID interrupt controller on an async host bus.
// Define IO_FAST_INTR_EN to build the FSEL register and the fast interrupt class.
module io_intr_port
  import io_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int N_CH   = N_CH_DEF
) (
  input  logic                    Clk,
  input  logic                    Rst_,
  input  logic [ADDR_W-1:0]       Addr,
  inout  wire  [DATA_W-1:0]       Data,
  input  logic                    CS_,
  input  logic                    RD_,
  input  logic                    WR_,
  input  logic                    Enable,
  input  logic [N_CH-1:0]         ev_in,
  input  logic                    int_ack,
  output logic                    fintr_req,
  output logic                    intr_req,
  output logic [$clog2(N_CH)-1:0] int_id
);

  localparam int ID_W  = $clog2(N_CH);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Reset gates every access so an in-flight write is dropped and Data is released at once.
  logic access, wr_en, rd_en, is_ctl;
  assign access = Enable & ~CS_ & Rst_;
  assign wr_en  = access & ~WR_;
  assign rd_en  = access & ~RD_ & WR_;
  assign is_ctl = Addr[ADDR_W-1];

  logic [ADDR_W-1:0] word_off;
  logic [IDX_W-1:0]  buf_idx;
  logic              unused_off_hi;
  assign word_off      = {1'b0, Addr[ADDR_W-2:0]} % ADDR_W'(DEPTH);
  assign buf_idx       = word_off[IDX_W-1:0];
  assign unused_off_hi = ^word_off[ADDR_W-1:IDX_W];

  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge Clk) begin
    if (wr_en && !is_ctl) mem[buf_idx] <= Data;
  end

  logic [N_CH-1:0] sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [N_CH-1:0] pend_q, pend_d, mask_q, mask_d, fsel_q, fsel_d;
  logic            ack_q, ack_d;
  logic [N_CH-1:0] rise, w1c, ack_clr, active, fast, normal;

  always_ff @(posedge Clk or negedge Rst_) begin
    if (!Rst_) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      fsel_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      fsel_q  <= fsel_d;
      ack_q   <= ack_d;
    end
  end

  assign active = pend_q & mask_q;
`ifdef IO_FAST_INTR_EN
  assign fast   = active & fsel_q;
  assign normal = active & ~fsel_q;
`else
  assign fast   = '0;
  assign normal = active;
`endif

  logic            fast_vld, norm_vld;
  logic [ID_W-1:0] fast_idx, norm_idx;

  io_prio_enc #(.N_CH(N_CH)) u_fast_enc (.req(fast),   .valid(fast_vld), .idx(fast_idx));
  io_prio_enc #(.N_CH(N_CH)) u_norm_enc (.req(normal), .valid(norm_vld), .idx(norm_idx));

  assign fintr_req = fast_vld;
  assign intr_req  = norm_vld & ~fast_vld;
  assign int_id    = fast_vld ? fast_idx : (norm_vld ? norm_idx : '0);

  always_comb begin
    sync1_d = ev_in;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    rise    = sync2_q & ~sync3_q;
    ack_d   = int_ack;
    ack_clr = '0;
    if (int_ack && !ack_q && (fintr_req || intr_req)) ack_clr[int_id] = 1'b1;
    w1c     = '0;
    mask_d  = mask_q;
    fsel_d  = '0;
`ifdef IO_FAST_INTR_EN
    fsel_d  = fsel_q;
`endif
    if (wr_en && is_ctl) begin
      case (ctl_reg_e'(Addr[1:0]))
        REG_PEND: w1c    = Data[N_CH-1:0];
        REG_MASK: mask_d = Data[N_CH-1:0];
`ifdef IO_FAST_INTR_EN
        REG_FSEL: fsel_d = Data[N_CH-1:0];
`endif
        default: ;
      endcase
    end
    // A fresh edge is OR-ed in last so it survives a same-cycle W1C or ack clear.
    pend_d = (pend_q & ~w1c & ~ack_clr) | rise;
  end

  logic [DATA_W-1:0] rd_word;
  always_comb begin
    rd_word = '0;
    if (is_ctl) begin
      case (ctl_reg_e'(Addr[1:0]))
        REG_PEND: rd_word[N_CH-1:0] = pend_q;
        REG_MASK: rd_word[N_CH-1:0] = mask_q;
        REG_FSEL: rd_word[N_CH-1:0] = fsel_q;
        REG_ID:   rd_word[ID_W+1:0] = {fintr_req, intr_req, int_id};
        default:  rd_word = '0;
      endcase
    end else begin
      rd_word = mem[buf_idx];
    end
  end

  assign Data = rd_en ? rd_word : 'z;

endmodule

// File: tb/tb_io_intr_port.sv
// tb_io_intr_port: directed bench for io_intr_port covering buffer access, interrupt classes,
// acknowledge, collisions and reset; the fast-class scenario is built when IO_FAST_INTR_EN is set.
module tb_io_intr_port;
  import io_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int DEP = 256;
  localparam int NC  = 4;

  localparam logic [AW-1:0] A_PEND = 10'h200;
  localparam logic [AW-1:0] A_MASK = 10'h201;
  localparam logic [AW-1:0] A_FSEL = 10'h202;
  localparam logic [AW-1:0] A_ID   = 10'h203;

  // Clock and reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  io_intr_port_if #(.ADDR_W(AW), .N_CH(NC)) bus_if ();

  wire  [DW-1:0] data;
  logic          tb_drv;
  logic [DW-1:0] tb_data;
  assign data = tb_drv ? tb_data : 'z;

  int total;
  int bad;
  logic [DW-1:0] exp_q[$];

  io_intr_port #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .N_CH(NC)) dut (
    .Clk       (clk),
    .Rst_      (rst_n),
    .Addr      (bus_if.Addr),
    .Data      (data),
    .CS_       (bus_if.CS_),
    .RD_       (bus_if.RD_),
    .WR_       (bus_if.WR_),
    .Enable    (bus_if.Enable),
    .ev_in     (bus_if.ev_in),
    .int_ack   (bus_if.int_ack),
    .fintr_req (bus_if.fintr_req),
    .intr_req  (bus_if.intr_req),
    .int_id    (bus_if.int_id)
  );

  // Driver tasks
  task automatic idle_bus();
    bus_if.CS_    = 1'b1;
    bus_if.RD_    = 1'b1;
    bus_if.WR_    = 1'b1;
    bus_if.Enable = 1'b0;
    tb_drv        = 1'b0;
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] v, input logic en);
    @(negedge clk);
    bus_if.Addr   = a;
    tb_data       = v;
    tb_drv        = 1'b1;
    bus_if.Enable = en;
    bus_if.CS_    = 1'b0;
    bus_if.WR_    = 1'b0;
    bus_if.RD_    = 1'b1;
    @(negedge clk);
    idle_bus();
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [DW-1:0] v);
    @(negedge clk);
    bus_if.Addr   = a;
    tb_drv        = 1'b0;
    bus_if.Enable = 1'b1;
    bus_if.CS_    = 1'b0;
    bus_if.WR_    = 1'b1;
    bus_if.RD_    = 1'b0;
    #1;
    v = data;
    idle_bus();
  endtask

  task automatic raise_ev(input logic [NC-1:0] ev);
    @(negedge clk);
    bus_if.ev_in = ev;
    repeat (3) @(negedge clk);
    bus_if.ev_in = '0;
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    bus_if.int_ack = 1'b1;
    @(negedge clk);
    bus_if.int_ack = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    logic [DW-1:0] v;
    rst_n = 1'b0;
    idle_bus();
    bus_if.Addr    = '0;
    bus_if.ev_in   = '0;
    bus_if.int_ack = 1'b0;
    tb_data        = '0;
    repeat (2) @(negedge clk);
    total++; if (bus_if.fintr_req !== 1'b0) begin bad++; $display("FAIL reset_fintr got=%b exp=0", bus_if.fintr_req); end
    total++; if (bus_if.intr_req !== 1'b0) begin bad++; $display("FAIL reset_intr got=%b exp=0", bus_if.intr_req); end
    total++; if (bus_if.int_id !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d exp=0", bus_if.int_id); end
    rst_n = 1'b1;
    bus_read(A_PEND, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_pend got=%h exp=0", v); end
    bus_read(A_MASK, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_mask got=%h exp=0", v); end
  endtask

  task automatic test_buffer();
    logic [DW-1:0] v;
    bus_write(10'd5, 32'hDEADBEEF, 1'b1);
    exp_q.push_back(32'hDEADBEEF);
    bus_read(10'd5, v);
    total++; if (v !== exp_q[0]) begin bad++; $display("FAIL buf_rw got=%h exp=%h", v, exp_q[0]); end
    void'(exp_q.pop_front());

    bus_write(10'd5, 32'h11111111, 1'b0);
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    bus_if.Addr = 10'd5; bus_if.CS_ = 1'b0; bus_if.RD_ = 1'b0; bus_if.Enable = 1'b0;
    tb_drv = 1'b1; tb_data = 32'h13572468;
    #1;
    total++; if (data !== 32'h13572468) begin bad++; $display("FAIL buf_en0_release got=%h exp=%h", data, 32'h13572468); end
    idle_bus();
    bus_read(10'd5, v);
    total++; if (v !== exp_q[0]) begin bad++; $display("FAIL buf_en0_nowrite got=%h exp=%h", v, exp_q[0]); end
    void'(exp_q.pop_front());

    // Address 261 folds onto word 5 of a 256-word buffer.
    bus_write(10'd261, 32'hCAFEF00D, 1'b1);
    exp_q.push_back(32'hCAFEF00D);
    bus_read(10'd5, v);
    total++; if (v !== exp_q[0]) begin bad++; $display("FAIL buf_modulo got=%h exp=%h", v, exp_q[0]); end
    void'(exp_q.pop_front());

    bus_write(10'd7, 32'hFFFF0000, 1'b1);
    @(negedge clk);
    bus_if.Addr = 10'd7; bus_if.CS_ = 1'b0; bus_if.RD_ = 1'b0; bus_if.WR_ = 1'b0; bus_if.Enable = 1'b1;
    tb_drv = 1'b1; tb_data = 32'h0BADF00D;
    #1;
    total++; if (data !== 32'h0BADF00D) begin bad++; $display("FAIL buf_wr_rd_nodrive got=%h exp=%h", data, 32'h0BADF00D); end
    @(negedge clk);
    idle_bus();
    exp_q.push_back(32'h0BADF00D);
    bus_read(10'd7, v);
    total++; if (v !== exp_q[0]) begin bad++; $display("FAIL buf_wr_rd_write got=%h exp=%h", v, exp_q[0]); end
    void'(exp_q.pop_front());

    bus_write(A_MASK, 32'hFFFFFFFF, 1'b1);
    bus_read(A_MASK, v);
    total++; if (v !== 32'h0000000F) begin bad++; $display("FAIL mask_upper_zero got=%h exp=%h", v, 32'h0000000F); end
    bus_write(A_MASK, 32'h0, 1'b1);
  endtask

  task automatic test_normal();
    logic [DW-1:0] v;
    bus_write(A_MASK, 32'h3, 1'b1);
    bus_write(A_FSEL, 32'h0, 1'b1);
    @(negedge clk);
    bus_if.ev_in = 4'b0010;
    repeat (2) @(negedge clk);
    total++; if (bus_if.intr_req !== 1'b0) begin bad++; $display("FAIL normal_before_3rd got=%b exp=0", bus_if.intr_req); end
    @(negedge clk);
    total++; if (bus_if.intr_req !== 1'b1) begin bad++; $display("FAIL normal_intr got=%b exp=1", bus_if.intr_req); end
    total++; if (bus_if.int_id !== 2'd1) begin bad++; $display("FAIL normal_id got=%0d exp=1", bus_if.int_id); end
    total++; if (bus_if.fintr_req !== 1'b0) begin bad++; $display("FAIL normal_fintr got=%b exp=0", bus_if.fintr_req); end
    bus_if.ev_in = '0;
    bus_read(A_ID, v);
    total++; if (v !== 32'h5) begin bad++; $display("FAIL normal_id_reg got=%h exp=%h", v, 32'h5); end
    bus_read(A_PEND, v);
    total++; if (v !== 32'h2) begin bad++; $display("FAIL normal_pend got=%h exp=%h", v, 32'h2); end
    ack_pulse();
    total++; if (bus_if.intr_req !== 1'b0) begin bad++; $display("FAIL normal_ack_clear got=%b exp=0", bus_if.intr_req); end
    bus_read(A_PEND, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL normal_pend_after_ack got=%h exp=0", v); end
  endtask

  task automatic test_mask();
    logic [DW-1:0] v;
    bus_write(A_MASK, 32'h0, 1'b1);
    raise_ev(4'b0001);
    total++; if (bus_if.intr_req !== 1'b0) begin bad++; $display("FAIL masked_no_req got=%b exp=0", bus_if.intr_req); end
    bus_read(A_PEND, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL masked_pend got=%h exp=%h", v, 32'h1); end
    ack_pulse();
    bus_read(A_PEND, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL ack_ignored_pend got=%h exp=%h", v, 32'h1); end
    bus_write(A_MASK, 32'h1, 1'b1);
    total++; if (bus_if.intr_req !== 1'b1) begin bad++; $display("FAIL unmask_req got=%b exp=1", bus_if.intr_req); end
    total++; if (bus_if.int_id !== 2'd0) begin bad++; $display("FAIL unmask_id got=%0d exp=0", bus_if.int_id); end
    // A held-high ack clears once, then must not clear a later request.
    @(negedge clk);
    bus_if.int_ack = 1'b1;
    @(negedge clk);
    total++; if (bus_if.intr_req !== 1'b0) begin bad++; $display("FAIL ack_edge_clear got=%b exp=0", bus_if.intr_req); end
    raise_ev(4'b0001);
    total++; if (bus_if.intr_req !== 1'b1) begin bad++; $display("FAIL ack_level_no_clear got=%b exp=1", bus_if.intr_req); end
    bus_if.int_ack = 1'b0;
    bus_write(A_PEND, 32'h1, 1'b1);
    total++; if (bus_if.intr_req !== 1'b0) begin bad++; $display("FAIL w1c_clear got=%b exp=0", bus_if.intr_req); end
    bus_write(A_MASK, 32'h0, 1'b1);
  endtask

  task automatic test_collision();
    logic [DW-1:0] v;
    bus_write(A_MASK, 32'h8, 1'b1);
    raise_ev(4'b1000);
    total++; if (bus_if.int_id !== 2'd3 || bus_if.intr_req !== 1'b1) begin bad++; $display("FAIL coll_setup got=%b/%0d exp=1/3", bus_if.intr_req, bus_if.int_id); end
    @(negedge clk);
    bus_if.ev_in = 4'b1000;
    @(negedge clk);
    bus_write(A_PEND, 32'h8, 1'b1);
    bus_if.ev_in = '0;
    bus_read(A_PEND, v);
    total++; if (v !== 32'h8) begin bad++; $display("FAIL collision_w1c got=%h exp=%h", v, 32'h8); end
    @(negedge clk);
    bus_if.ev_in = 4'b1000;
    repeat (2) @(negedge clk);
    bus_if.int_ack = 1'b1;
    @(negedge clk);
    bus_if.int_ack = 1'b0;
    bus_if.ev_in = '0;
    total++; if (bus_if.intr_req !== 1'b1) begin bad++; $display("FAIL collision_ack got=%b exp=1", bus_if.intr_req); end
    ack_pulse();
    bus_read(A_PEND, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL collision_final_pend got=%h exp=0", v); end
    bus_write(A_MASK, 32'h0, 1'b1);
  endtask

`ifdef IO_FAST_INTR_EN
  task automatic test_fast();
    logic [DW-1:0] v;
    bus_write(A_FSEL, 32'h4, 1'b1);
    bus_write(A_MASK, 32'hF, 1'b1);
    bus_read(A_FSEL, v);
    total++; if (v !== 32'h4) begin bad++; $display("FAIL fast_fsel_rd got=%h exp=%h", v, 32'h4); end
    raise_ev(4'b0101);
    total++; if (bus_if.fintr_req !== 1'b1) begin bad++; $display("FAIL fast_fintr got=%b exp=1", bus_if.fintr_req); end
    total++; if (bus_if.intr_req !== 1'b0) begin bad++; $display("FAIL fast_intr_pre got=%b exp=0", bus_if.intr_req); end
    total++; if (bus_if.int_id !== 2'd2) begin bad++; $display("FAIL fast_id got=%0d exp=2", bus_if.int_id); end
    bus_read(A_ID, v);
    total++; if (v !== 32'hA) begin bad++; $display("FAIL fast_id_reg got=%h exp=%h", v, 32'hA); end
    ack_pulse();
    total++; if (bus_if.fintr_req !== 1'b0 || bus_if.intr_req !== 1'b1) begin bad++; $display("FAIL fast_after_ack got=%b/%b exp=0/1", bus_if.fintr_req, bus_if.intr_req); end
    total++; if (bus_if.int_id !== 2'd0) begin bad++; $display("FAIL fast_after_ack_id got=%0d exp=0", bus_if.int_id); end
    ack_pulse();
    total++; if (bus_if.intr_req !== 1'b0) begin bad++; $display("FAIL fast_final got=%b exp=0", bus_if.intr_req); end
    bus_write(A_FSEL, 32'h0, 1'b1);
    bus_write(A_MASK, 32'h0, 1'b1);
  endtask
`else
  task automatic test_no_fast();
    logic [DW-1:0] v;
    bus_write(A_FSEL, 32'hF, 1'b1);
    bus_read(A_FSEL, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL nofast_fsel_rd got=%h exp=0", v); end
    bus_write(A_MASK, 32'h1, 1'b1);
    raise_ev(4'b0001);
    total++; if (bus_if.fintr_req !== 1'b0) begin bad++; $display("FAIL nofast_fintr got=%b exp=0", bus_if.fintr_req); end
    total++; if (bus_if.intr_req !== 1'b1) begin bad++; $display("FAIL nofast_intr got=%b exp=1", bus_if.intr_req); end
    total++; if (bus_if.int_id !== 2'd0) begin bad++; $display("FAIL nofast_id got=%0d exp=0", bus_if.int_id); end
    ack_pulse();
    total++; if (bus_if.intr_req !== 1'b0) begin bad++; $display("FAIL nofast_ack got=%b exp=0", bus_if.intr_req); end
    bus_write(A_MASK, 32'h0, 1'b1);
  endtask
`endif

  task automatic test_reset_mid_write();
    logic [DW-1:0] v;
    bus_write(A_MASK, 32'h2, 1'b1);
    raise_ev(4'b0010);
    total++; if (bus_if.intr_req !== 1'b1) begin bad++; $display("FAIL rst_setup got=%b exp=1", bus_if.intr_req); end
    @(negedge clk);
    bus_if.Addr = 10'd5; bus_if.CS_ = 1'b0; bus_if.WR_ = 1'b0; bus_if.RD_ = 1'b1; bus_if.Enable = 1'b1;
    tb_drv = 1'b1; tb_data = 32'h55AA55AA;
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus_if.intr_req !== 1'b0 || bus_if.fintr_req !== 1'b0) begin bad++; $display("FAIL rst_mid_req got=%b/%b exp=0/0", bus_if.intr_req, bus_if.fintr_req); end
    total++; if (bus_if.int_id !== 2'd0) begin bad++; $display("FAIL rst_mid_id got=%0d exp=0", bus_if.int_id); end
    @(negedge clk);
    bus_if.WR_ = 1'b1; bus_if.RD_ = 1'b0;
    tb_data = 32'h0F0F0F0F;
    #1;
    total++; if (data !== 32'h0F0F0F0F) begin bad++; $display("FAIL rst_data_release got=%h exp=%h", data, 32'h0F0F0F0F); end
    idle_bus();
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(32'hCAFEF00D);
    bus_read(10'd5, v);
    total++; if (v !== exp_q[0]) begin bad++; $display("FAIL rst_write_aborted got=%h exp=%h", v, exp_q[0]); end
    void'(exp_q.pop_front());
    bus_read(A_PEND, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_pend got=%h exp=0", v); end
    bus_read(A_MASK, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_mask got=%h exp=0", v); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_buffer();
    test_normal();
    test_mask();
    test_collision();
`ifdef IO_FAST_INTR_EN
    test_fast();
`else
    test_no_fast();
`endif
    test_reset_mid_write();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_intr_port.md
IO_INTR_PORT -- requirements
Module: io_intr_port

Interface
REQ-001 SHALL have parameters: DATA_W, default 32, data bus width; ADDR_W, default 10, address width; DEPTH, default 256, buffer words (DEPTH <= 2^(ADDR_W-1)); N_CH, default 4, interrupt channels (2..16).
REQ-002 SHALL have ports (name, direction, width, meaning):
- Clk, in, 1, sole clock, rising edge.
- Rst_, in, 1, asynchronous active-low reset.
- Addr, in, ADDR_W, word address.
- Data, inout, DATA_W, bidirectional data bus.
- CS_, in, 1, chip select, active low.
- RD_, in, 1, read strobe, active low.
- WR_, in, 1, write strobe, active low.
- Enable, in, 1, ISR access enable, active high.
- ev_in, in, N_CH, asynchronous event lines.
- int_ack, in, 1, interrupt acknowledge.
- fintr_req, out, 1, fast interrupt request.
- intr_req, out, 1, normal interrupt request.
- int_id, out, clog2(N_CH), channel being requested.

Function
REQ-003 SHALL decode accesses by Addr[ADDR_W-1]: 0 = buffer word Addr modulo DEPTH; 1 = control register at Addr[1:0] (0 PEND, 1 MASK, 2 FSEL, 3 ID).
REQ-004 SHALL drive Data asynchronously with the addressed word iff Enable & !CS_ & !RD_; otherwise Data SHALL be high-Z.
REQ-005 SHALL write on rising Clk iff Enable & !CS_ & !WR_; a write with RD_ also low is still performed, and Data is not driven by this block.
REQ-006 SHALL treat PEND as read / write-1-to-clear; MASK and FSEL as read/write (low N_CH bits); ID as read-only {fintr_req, intr_req, int_id}. Unused upper bits SHALL read 0.
REQ-007 SHALL pass each ev_in bit through a 2-flop synchronizer and a rising-edge detector; PEND[i] SHALL set on the 3rd rising Clk after ev_in[i] rises, provided the level is held for at least 2 cycles.
REQ-008 SHALL define: active = PEND & MASK; fast = active & FSEL; normal = active & ~FSEL.
REQ-009 SHALL make fintr_req = |fast and intr_req = (|normal) & ~(|fast), both from registered state with no extra latency; the fast class preempts normal.
REQ-010 SHALL set int_id to the lowest-index bit of fast if any, else the lowest-index bit of normal, else 0.
REQ-011 SHALL detect rising edges of int_ack synchronously; each edge SHALL clear PEND[int_id] as valued in that cycle, and SHALL be ignored when no request is active.
REQ-012 SHALL resolve simultaneous events by letting a new event win: a new edge on the same cycle as an ack-clear or a W1C clear of that bit leaves it set.
REQ-013 SHALL allow MASK changes without losing pending state; a masked bit stays pending and requests once it is unmasked.

Reset
REQ-014 SHALL, while Rst_ = 0, clear PEND, MASK, FSEL, the synchronizers and the ack edge-detect flop; fintr_req, intr_req and int_id SHALL be 0.
REQ-015 SHALL not reset buffer contents; reset asserted mid-access SHALL abort any write and release Data to high-Z within the same cycle.

Configuration
REQ-016 SHALL, with IO_FAST_INTR_EN defined, implement FSEL and fintr_req as specified.
REQ-017 SHALL, without IO_FAST_INTR_EN, tie fintr_req to 0, have FSEL read 0 and ignore writes to it, and route all active channels to intr_req.

Structure
REQ-018 SHALL place the control-register offsets (PEND/MASK/FSEL/ID) and the default parameter values in a shared package, io_pkg.
REQ-019 SHALL implement the lowest-index priority encoder as the sub-module io_prio_enc (N_CH parameter; outputs valid and index).

Verification
REQ-020 Reset: with Rst_ = 0 mid-write, all outputs are 0 and Data is Z; after release, PEND and MASK read 0.
REQ-021 Buffer: write 0xDEADBEEF at Addr 5 with Enable = 1, then read back 0xDEADBEEF; the same write with Enable = 0 leaves the word unchanged and Data stays Z.
REQ-022 Normal interrupt: with MASK = 0x3 and FSEL = 0, pulse ev_in[1] for 3 cycles; intr_req = 1 and int_id = 1 on the 3rd edge; an int_ack edge clears it within 1 cycle.
REQ-023 Preemption: with FSEL = 0x4, MASK = 0xF, raise ev_in[0] and ev_in[2] together; fintr_req = 1, int_id = 2 and intr_req = 0; after the ack, intr_req = 1 and int_id = 0.
REQ-024 Collision: ev_in[3] edge detected in the same cycle as a W1C of PEND[3]; PEND reads 0x8.
REQ-025 Macro off: rebuild without IO_FAST_INTR_EN, write FSEL = 0xF, raise ev_in[0]; fintr_req = 0, intr_req = 1, and FSEL reads 0.
